mips_div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage; executes DIV/DIVU flagged by the ID-stage control decode (div_valid, signed_div).
- Operands and control arrive from the ID/EX pipeline register, never directly from the decoder. This avoids a combinational loop through stall.
- Stalls the pipeline while iterating and delivers {remainder, quotient} for the HI/LO write.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 32 +++
 rtl/mips_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mips_div_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider: state encoding,
// operand width, iteration counter width and the divide-by-zero quotient.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  // Quotient delivered for any divide by zero, signed or unsigned.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude on WIDTH+1 bits and
// keep the difference only when it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; the top bit of the difference is the borrow.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {1'b0, dvs_mag};
    if (diff_s[WIDTH] == 1'b0) begin
      q_bit   = 1'b1;
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mips_div_unit.sv
// EX-stage DIV/DIVU unit: radix-2 restoring divider that stalls the pipe while
// iterating and presents {remainder, quotient} for the HI/LO write.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle
// instead of running the full iteration sequence.
module mips_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_valid,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  input  logic               ex_advance,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_QUO =
    (WIDTH == DIV_WIDTH) ? WIDTH'(DIV_ZERO_QUO) : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;         // dividend bits out, quotient bits in
  logic [WIDTH-1:0]   rem_q, rem_d;         // partial remainder
  logic [WIDTH-1:0]   dvs_q, dvs_d;         // divisor magnitude
  logic [WIDTH-1:0]   raw_dvd_q, raw_dvd_d; // unmodified rs for divide by zero
  logic               zero_q, zero_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               start_s;
  logic               dvd_neg_s;
  logic               dvs_neg_s;
  logic [WIDTH-1:0]   step_rem_s;
  logic               step_q_s;
  logic [WIDTH-1:0]   fin_quo_s;
  logic [WIDTH-1:0]   fin_rem_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .dvs_mag (dvs_q),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  assign start_s   = div_valid & ~annul;
  assign dvd_neg_s = signed_div & dividend[WIDTH-1];
  assign dvs_neg_s = signed_div & divisor[WIDTH-1];
  assign fin_quo_s = {quo_q[WIDTH-2:0], step_q_s};
  assign fin_rem_s = step_rem_s;

  assign ready  = (state_q == ST_DONE);
  assign result = result_q;

  // Next-state, iteration datapath, sign fix-up and pipeline stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    raw_dvd_d = raw_dvd_q;
    zero_d    = zero_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    stall_div = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_div = start_s;
        if (start_s) begin
          quo_d     = dvd_neg_s ? (~dividend + ONE) : dividend;
          dvs_d     = dvs_neg_s ? (~divisor + ONE) : divisor;
          rem_d     = {WIDTH{1'b0}};
          raw_dvd_d = dividend;
          zero_d    = (divisor == {WIDTH{1'b0}});
          neg_quo_d = dvd_neg_s ^ dvs_neg_s;
          neg_rem_d = dvd_neg_s;
          cnt_d     = {CW{1'b0}};
`ifdef DIV_ZERO_FAST_EN
          if (divisor == {WIDTH{1'b0}}) begin
            state_d  = ST_DONE;
            result_d = {dividend, ZERO_QUO};
          end else begin
            state_d  = ST_BUSY;
          end
`else
          state_d   = ST_BUSY;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_div = 1'b1;
        if (annul) begin
          state_d = ST_IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          rem_d = step_rem_s;
          quo_d = fin_quo_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
            cnt_d   = {CW{1'b0}};
            if (zero_q) begin
              result_d = {raw_dvd_q, ZERO_QUO};
            end else begin
              result_d = {(neg_rem_q ? (~fin_rem_s + ONE) : fin_rem_s),
                          (neg_quo_q ? (~fin_quo_s + ONE) : fin_quo_s)};
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_DONE: begin
        if (ex_advance || annul) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and operand/result registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      raw_dvd_q <= {WIDTH{1'b0}};
      zero_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      raw_dvd_q <= raw_dvd_d;
      zero_q    <= zero_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed + small random bench for mips_div_unit. Expected results are queued
// at start and popped when ready rises; latency and stall are checked per cycle.
module tb_mips_div_unit;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        ex_advance;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'd0;

  mips_div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .annul      (annul),
    .ex_advance (ex_advance),
    .stall_div  (stall_div),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: HI = remainder, LO = quotient; truncating signed divide.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a; sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Called at a negedge with the DUT in IDLE: cycle 0 of a divide.
  task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expv, input bit push);
    div_valid  = 1'b1;
    signed_div = s;
    dividend   = a;
    divisor    = b;
    if (push) exp_q.push_back(expv);
    #1;
    check("start_flags", {62'd0, ready, stall_div}, 64'd1);
  endtask

  // Waits for ready (div_valid kept high) and checks latency, stall and result.
  task automatic wait_ready(input int lat, input string tag);
    int n;
    logic [63:0] e;
    for (n = 1; n < 200; n++) begin
      @(negedge clk);
      if (ready === 1'b1 || n > lat) break;
      check({tag, "_busy"}, {62'd0, ready, stall_div}, 64'd1);
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_done_flags"}, {62'd0, ready, stall_div}, 64'd2);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e);
      last_res = e;
    end
  endtask

  // Leave DONE via ex_advance with no new instruction behind it.
  task automatic advance();
    ex_advance = 1'b1;
    div_valid  = 1'b0;
    @(negedge clk);
    ex_advance = 1'b0;
    #1;
    check("idle_flags", {62'd0, ready, stall_div}, 64'd0);
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb;
    bit          seen;
    resetn = 1'b0; div_valid = 1'b0; signed_div = 1'b0;
    dividend = 32'd0; divisor = 32'd0; annul = 1'b0; ex_advance = 1'b0;
    #1;
    check("reset_flags", {62'd0, ready, stall_div}, 64'd0);
    check("reset_result", result, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // DIVU 100 / 7
    start_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b1);
    wait_ready(LAT, "divu_100_7");
    advance();

    // DIV -7 / 2
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    wait_ready(LAT, "div_m7_2");
    advance();

    // DIV most-negative / -1
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1);
    wait_ready(LAT, "div_ovf");
    advance();

    // Divide by zero, unsigned and signed
    start_div(1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1);
    wait_ready(ZLAT, "divu_zero");
    advance();
    start_div(1'b1, 32'h8765_4321, 32'd0, {32'h8765_4321, 32'hFFFF_FFFF}, 1'b1);
    wait_ready(ZLAT, "div_zero");
    advance();

    // annul at BUSY iteration 10 (cycle 11)
    start_div(1'b0, 32'd5000, 32'd3, 64'd0, 1'b0);
    repeat (11) @(negedge clk);
    annul = 1'b1; div_valid = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    #1;
    check("annul_flags", {62'd0, ready, stall_div}, 64'd0);
    check("annul_result_kept", result, last_res);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1'b1;
    end
    check("annul_no_ready", {63'd0, seen}, 64'd0);
    start_div(1'b0, 32'd5000, 32'd3, {32'd2, 32'd1666}, 1'b1);
    wait_ready(LAT, "after_annul");
    advance();

    // DONE hold with div_valid high, then back-to-back divide
    start_div(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b1);
    wait_ready(LAT, "hold_first");
    repeat (5) begin
      @(negedge clk);
      check("hold_flags", {62'd0, ready, stall_div}, 64'd2);
      check("hold_result", result, last_res);
    end
    ex_advance = 1'b1;
    @(negedge clk);
    ex_advance = 1'b0;
    start_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);
    wait_ready(LAT, "hold_next");
    advance();

    // Random operands against the reference model
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(1, 0));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(28, 0));
      start_div(rs, ra, rb, model(rs, ra, rb), 1'b1);
      wait_ready((rb == 32'd0) ? ZLAT : LAT, "random");
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
